// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared state enum, source indices and width default for mux_rr_arbiter
package mux_arb_pkg;

   localparam int WIDTH_DEFAULT = 32;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/mux_day1.sv
// rtl/mux_day1.sv - 2:1 data mux, sel_i=0 passes a_i, sel_i=1 passes b_i
module mux_day1 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sel_i,
   output logic [WIDTH-1:0] y
);

   assign y = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - two-requester arbiter feeding a one-entry output register
// MUX_RR_ARBITER_RR_EN: defined = round-robin tie-break, undefined = A wins ties
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic             a_valid_i,
   output logic             a_ready_o,
   input  logic [WIDTH-1:0] b_i,
   input  logic             b_valid_i,
   output logic             b_ready_o,
   output logic [WIDTH-1:0] y_o,
   output logic             y_valid_o,
   input  logic             y_ready_i,
   output logic             sel_o
);

   arb_state_e       state_q;
   logic [WIDTH-1:0] y_q;
   logic             sel_q;
   logic             last_grant_q;

   logic             can_accept;
   logic             win;
   logic             accept;
   logic [WIDTH-1:0] y_d;

   always_comb begin
      can_accept = (state_q == EMPTY) || y_ready_i;
`ifdef MUX_RR_ARBITER_RR_EN
      if (a_valid_i && b_valid_i) begin
         win = ~last_grant_q;
      end else if (a_valid_i) begin
         win = SRC_A;
      end else if (b_valid_i) begin
         win = SRC_B;
      end else begin
         win = last_grant_q;
      end
`else
      // Idle cycles fall back to last_grant_q; readies are gated by valid so it is harmless.
      if (a_valid_i) begin
         win = SRC_A;
      end else if (b_valid_i) begin
         win = SRC_B;
      end else begin
         win = last_grant_q;
      end
`endif
      a_ready_o = !rst_i && can_accept && a_valid_i && (win == SRC_A);
      b_ready_o = !rst_i && can_accept && b_valid_i && (win == SRC_B);
      accept    = a_ready_o || b_ready_o;
   end

   mux_day1 #(
      .WIDTH (WIDTH)
   ) u_data_mux (
      .a_i   (a_i),
      .b_i   (b_i),
      .sel_i (win),
      .y     (y_d)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= EMPTY;
         y_q          <= '0;
         sel_q        <= SRC_A;
         last_grant_q <= SRC_B;
      end else if (accept) begin
         state_q      <= FULL;
         y_q          <= y_d;
         sel_q        <= win;
         last_grant_q <= win;
      end else if ((state_q == FULL) && y_ready_i) begin
         state_q      <= EMPTY;
      end
   end

   assign y_o       = y_q;
   assign sel_o     = sel_q;
   assign y_valid_o = (state_q == FULL);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - vector table plus scoreboard bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

`ifdef MUX_RR_ARBITER_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] a_i, b_i;
   logic        a_valid_i, b_valid_i, y_ready_i;
   logic        a_ready_o, b_ready_o, y_valid_o, sel_o;
   logic [31:0] y_o;

   mux_rr_arbiter #(.WIDTH(32)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .a_i       (a_i),
      .a_valid_i (a_valid_i),
      .a_ready_o (a_ready_o),
      .b_i       (b_i),
      .b_valid_i (b_valid_i),
      .b_ready_o (b_ready_o),
      .y_o       (y_o),
      .y_valid_o (y_valid_o),
      .y_ready_i (y_ready_i),
      .sel_o     (sel_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rst;
      logic [31:0] a;
      logic        av;
      logic [31:0] b;
      logic        bv;
      logic        yr;
      logic        ear;
      logic        ebr;
   } vec_t;

   typedef struct packed {
      logic [31:0] d;
      logic        s;
   } beat_t;

   vec_t  vecs[$];
   beat_t sb[$];

   int          n_checks = 0;
   int          n_pass   = 0;
   logic        full_m   = 1'b0;
   logic [31:0] y_m      = 32'h0;
   logic        sel_m    = 1'b0;

   function automatic vec_t mk(logic rst, logic [31:0] a, logic av, logic [31:0] b, logic bv,
                               logic yr, logic ear, logic ebr);
      vec_t v;
      v.rst = rst; v.a = a; v.av = av; v.b = b; v.bv = bv; v.yr = yr; v.ear = ear; v.ebr = ebr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step(input vec_t v, input string tag);
      beat_t e;
      rst_i = v.rst; a_i = v.a; a_valid_i = v.av; b_i = v.b; b_valid_i = v.bv; y_ready_i = v.yr;
      @(negedge clk_i);
      chk({tag, ".a_ready"}, {31'b0, a_ready_o}, {31'b0, v.ear});
      chk({tag, ".b_ready"}, {31'b0, b_ready_o}, {31'b0, v.ebr});
      chk({tag, ".y_valid"}, {31'b0, y_valid_o}, {31'b0, full_m});
      chk({tag, ".y"}, y_o, y_m);
      chk({tag, ".sel"}, {31'b0, sel_o}, {31'b0, sel_m});
      if (!v.rst && full_m && v.yr) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL %s.sb_underflow: got consume expected no beat", tag);
         end else begin
            e = sb.pop_front();
            chk({tag, ".pop_y"}, y_o, e.d);
            chk({tag, ".pop_sel"}, {31'b0, sel_o}, {31'b0, e.s});
         end
      end
      if (v.rst) begin
         sb.delete();
         full_m = 1'b0; y_m = 32'h0; sel_m = 1'b0;
      end else if (v.ear || v.ebr) begin
         e.d = v.ear ? v.a : v.b;
         e.s = v.ebr;
         sb.push_back(e);
         full_m = 1'b1; y_m = e.d; sel_m = e.s;
      end else if (v.yr) begin
         full_m = 1'b0;
      end
      @(posedge clk_i);
      #1;
   endtask

   localparam logic [31:0] A_T = 32'h1100;
   localparam logic [31:0] B_T = 32'h1010;

   initial begin
      // reset pair, single requester, reset, 4-cycle tie, drain
      vecs.push_back(mk(1, A_T, 1, B_T, 1, 1, 0, 0));
      vecs.push_back(mk(1, A_T, 1, B_T, 1, 1, 0, 0));
      vecs.push_back(mk(0, 32'h0110, 1, 32'h0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 32'h0, 0, 32'h0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 32'h0, 0, 32'h0, 0, 1, 0, 0));
      vecs.push_back(mk(0, A_T, 1, B_T, 1, 1, 1, 0));
      vecs.push_back(mk(0, A_T, 1, B_T, 1, 1, !RR, RR));
      vecs.push_back(mk(0, A_T, 1, B_T, 1, 1, 1, 0));
      vecs.push_back(mk(0, A_T, 1, B_T, 1, 1, !RR, RR));
      vecs.push_back(mk(0, 32'h0, 0, 32'h0, 0, 1, 0, 0));
      // backpressure: hold 0101 three cycles, then release with no bubble
      vecs.push_back(mk(0, 32'h0101, 1, 32'h0, 0, 1, 1, 0));
      vecs.push_back(mk(0, A_T, 1, B_T, 1, 0, 0, 0));
      vecs.push_back(mk(0, A_T, 1, B_T, 1, 0, 0, 0));
      vecs.push_back(mk(0, A_T, 1, B_T, 1, 0, 0, 0));
      vecs.push_back(mk(0, A_T, 1, B_T, 1, 1, !RR, RR));
      vecs.push_back(mk(0, 32'h0, 0, 32'h0, 0, 1, 0, 0));
      // reset while FULL discards the beat; first tie afterwards goes to A
      vecs.push_back(mk(0, 32'h1011, 1, 32'h0, 0, 0, 1, 0));
      vecs.push_back(mk(1, A_T, 1, B_T, 1, 1, 0, 0));
      vecs.push_back(mk(0, A_T, 1, B_T, 1, 0, 1, 0));
      vecs.push_back(mk(0, 32'h0, 0, 32'h0, 0, 1, 0, 0));

      rst_i = 1'b1; a_i = '0; b_i = '0; a_valid_i = 1'b0; b_valid_i = 1'b0; y_ready_i = 1'b0;
      @(posedge clk_i);
      #1;

      for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

      // back-to-back A beats at full throughput, then B dropping valid under backpressure
      step(mk(0, 32'hA000_0001, 1, 32'h0, 0, 1, 1, 0), "thr0");
      step(mk(0, 32'hA000_0002, 1, 32'h0, 0, 1, 1, 0), "thr1");
      step(mk(0, 32'hA000_0003, 1, 32'h0, 0, 1, 1, 0), "thr2");
      step(mk(0, 32'h0, 0, 32'hB000_0001, 1, 0, 0, 0), "drop0");
      step(mk(0, 32'h0, 0, 32'h0, 0, 0, 0, 0), "drop1");
      step(mk(0, A_T, 1, B_T, 1, 1, !RR, RR), "drop2");
      step(mk(0, 32'h0, 0, 32'h0, 0, 1, 0, 0), "drop3");
      step(mk(0, 32'h0, 0, 32'h0, 0, 1, 0, 0), "idle");

      n_checks++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL sb_leftover: got %0d beats expected 0", sb.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
